e203_exu_alu_share_arb: RTL and testbench

- Arbiter and sequencer for the shared EXU ALU datapath.
- Four requesters compete for the one datapath: ALU, BJP, AGU and MDV (shared muldiv). The block issues exactly one one-hot datapath select per cycle.
- Multi-cycle AGU (AMO) and MDV (iterative mul/div) operations can lock the datapath, including the two 33-bit shared buffers, for many cycles. The block owns that lock, the ownership of those buffers, and round-robin fairness between requesters.

---
 rtl/e203_exu_alu_share_arb.sv | 145 ++++++++++++++
 tb/tb_e203_exu_alu_share_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_alu_share_arb.sv
// Round-robin arbiter for the shared EXU ALU datapath with multi-cycle lock ownership,
// shared-buffer source selection and a sticky lock watchdog.
module e203_exu_alu_share_arb #(
    parameter int LOCK_TO = 64,
    parameter int CNT_W   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       alu_req_vld,
    input  logic       bjp_req_vld,
    input  logic       agu_req_vld,
    input  logic       mdv_req_vld,
    input  logic       agu_req_lock,
    input  logic       mdv_req_lock,
    output logic       alu_req_rdy,
    output logic       bjp_req_rdy,
    output logic       agu_req_rdy,
    output logic       mdv_req_rdy,
    output logic       alu_req_alu,
    output logic       bjp_req_alu,
    output logic       agu_req_alu,
    output logic       muldiv_req_alu,
    input  logic [1:0] agu_sbf_ena_in,
    input  logic [1:0] mdv_sbf_ena_in,
    output logic [1:0] sbf_ena,
    output logic       sbf_sel_mdv,
    output logic       locked,
    output logic       lock_err
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_err_q, lock_err_d;
    logic             sbf_sel_q, sbf_sel_d;

    logic [3:0] vld, gnt;
    logic [1:0] win, cur, idx;
    logic       hs, cur_lock, wd_hit;

    // Requester index order: 0 = ALU, 1 = BJP, 2 = AGU, 3 = MDV
    assign vld = {mdv_req_vld, agu_req_vld, bjp_req_vld, alu_req_vld};

    // Walk from the farthest slot back to rr_ptr so the nearest valid requester wins
    always_comb begin
        win = rr_ptr_q;
        idx = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr_q + 2'(k);
            if (vld[idx]) win = idx;
        end
    end

    always_comb begin
        gnt = '0;
        if (!rst && !flush) begin
            if (state_q == LOCKED) gnt[owner_q] = vld[owner_q];
            else if (vld[win])     gnt[win]     = 1'b1;
        end
    end

    assign hs       = |gnt;
    assign cur      = (state_q == LOCKED) ? owner_q : win;
    assign cur_lock = ((cur == 2'd2) && agu_req_lock) || ((cur == 2'd3) && mdv_req_lock);
    assign wd_hit   = (state_q == LOCKED) && (lock_cnt_q == CNT_W'(LOCK_TO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 2'd0;
            owner_q    <= 2'd0;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
            sbf_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
            sbf_sel_q  <= sbf_sel_d;
        end
    end

    // Flush wins over any same-cycle handshake; rr_ptr, lock_err and buffer source survive it
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        sbf_sel_d  = sbf_sel_q;
        lock_err_d = lock_err_q | wd_hit;
        if (flush) begin
            state_d    = IDLE;
            owner_d    = 2'd0;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        if (win == 2'd3)      sbf_sel_d = 1'b1;
                        else if (win == 2'd2) sbf_sel_d = 1'b0;
                        if (cur_lock) begin
                            state_d    = LOCKED;
                            owner_d    = win;
                            lock_cnt_d = CNT_W'(1);
                        end else begin
                            rr_ptr_d = win + 2'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (lock_cnt_q != '1) lock_cnt_d = lock_cnt_q + 1'b1;
                    if (hs && !cur_lock) begin
                        state_d    = IDLE;
                        owner_d    = 2'd0;
                        lock_cnt_d = '0;
                        rr_ptr_d   = owner_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        alu_req_rdy    = gnt[0];
        bjp_req_rdy    = gnt[1];
        agu_req_rdy    = gnt[2];
        mdv_req_rdy    = gnt[3];
        alu_req_alu    = gnt[0];
        bjp_req_alu    = gnt[1];
        agu_req_alu    = gnt[2];
        muldiv_req_alu = gnt[3];
        sbf_ena        = 2'b00;
        if (gnt[3])      sbf_ena = mdv_sbf_ena_in;
        else if (gnt[2]) sbf_ena = agu_sbf_ena_in;
        sbf_sel_mdv    = sbf_sel_q;
        locked         = (state_q == LOCKED);
        lock_err       = lock_err_q | wd_hit;
    end
endmodule

// File: tb/tb_e203_exu_alu_share_arb.sv
// Directed and randomized bench for e203_exu_alu_share_arb against a cycle-level behavioural model.
module tb_e203_exu_alu_share_arb;
    localparam int LOCK_TO = 64;
    localparam int CNT_W   = 7;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       alu_req_vld = 1'b0, bjp_req_vld = 1'b0, agu_req_vld = 1'b0, mdv_req_vld = 1'b0;
    logic       agu_req_lock = 1'b0, mdv_req_lock = 1'b0;
    logic       alu_req_rdy, bjp_req_rdy, agu_req_rdy, mdv_req_rdy;
    logic       alu_req_alu, bjp_req_alu, agu_req_alu, muldiv_req_alu;
    logic [1:0] agu_sbf_ena_in = 2'b00, mdv_sbf_ena_in = 2'b00;
    logic [1:0] sbf_ena;
    logic       sbf_sel_mdv, locked, lock_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the arbiter
    bit m_locked;
    int m_owner;
    int m_rr;
    int m_cnt;
    bit m_err;
    bit m_sel;

    e203_exu_alu_share_arb #(.LOCK_TO(LOCK_TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_req_vld(alu_req_vld), .bjp_req_vld(bjp_req_vld),
        .agu_req_vld(agu_req_vld), .mdv_req_vld(mdv_req_vld),
        .agu_req_lock(agu_req_lock), .mdv_req_lock(mdv_req_lock),
        .alu_req_rdy(alu_req_rdy), .bjp_req_rdy(bjp_req_rdy),
        .agu_req_rdy(agu_req_rdy), .mdv_req_rdy(mdv_req_rdy),
        .alu_req_alu(alu_req_alu), .bjp_req_alu(bjp_req_alu),
        .agu_req_alu(agu_req_alu), .muldiv_req_alu(muldiv_req_alu),
        .agu_sbf_ena_in(agu_sbf_ena_in), .mdv_sbf_ena_in(mdv_sbf_ena_in),
        .sbf_ena(sbf_ena), .sbf_sel_mdv(sbf_sel_mdv),
        .locked(locked), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_err = 0; m_sel = 0;
    endtask

    function automatic logic [3:0] cur_vld();
        return {mdv_req_vld, agu_req_vld, bjp_req_vld, alu_req_vld};
    endfunction

    // Expected one-hot grant: owner only while locked, else first valid from rr pointer
    function automatic logic [3:0] exp_gnt(input logic [3:0] v);
        logic [3:0] g;
        g = 4'b0000;
        if (rst || flush) return g;
        if (m_locked) begin
            if (v[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int k = 0; k < 4; k++) begin
            if (v[(m_rr + k) % 4]) begin
                g[(m_rr + k) % 4] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic check_all(input string tag, input logic [3:0] g);
        logic [1:0] e_ena;
        e_ena = g[3] ? mdv_sbf_ena_in : (g[2] ? agu_sbf_ena_in : 2'b00);
        chk({tag, ".rdy"}, {4'h0, mdv_req_rdy, agu_req_rdy, bjp_req_rdy, alu_req_rdy}, {4'h0, g});
        chk({tag, ".sel"}, {4'h0, muldiv_req_alu, agu_req_alu, bjp_req_alu, alu_req_alu}, {4'h0, g});
        chk({tag, ".sbf_ena"}, {6'h0, sbf_ena}, {6'h0, e_ena});
        chk({tag, ".sbf_sel_mdv"}, {7'h0, sbf_sel_mdv}, {7'h0, m_sel});
        chk({tag, ".locked"}, {7'h0, locked}, {7'h0, m_locked});
        chk({tag, ".lock_err"}, {7'h0, lock_err}, {7'h0, (m_err || (m_locked && m_cnt == LOCK_TO))});
    endtask

    // Called at posedge+1 with inputs already set; checks mid-cycle and advances the model
    task automatic step(input string tag);
        logic [3:0] g;
        int  w;
        bit  lk;
        bit  new_err;
        #4;
        g = exp_gnt(cur_vld());
        check_all(tag, g);
        @(posedge clk);
        new_err = m_err || (m_locked && m_cnt == LOCK_TO);
        w = 0;
        for (int i = 0; i < 4; i++) if (g[i]) w = i;
        lk = (w == 2) ? agu_req_lock : ((w == 3) ? mdv_req_lock : 1'b0);
        if (flush) begin
            m_locked = 0; m_cnt = 0;
        end else if (m_locked) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (g != 0 && !lk) begin
                m_locked = 0; m_cnt = 0; m_rr = (w + 1) % 4;
            end
        end else if (g != 0) begin
            if (w == 3) m_sel = 1;
            if (w == 2) m_sel = 0;
            if (lk) begin
                m_locked = 1; m_owner = w; m_cnt = 1;
            end else begin
                m_rr = (w + 1) % 4;
            end
        end
        m_err = new_err;
        #1;
    endtask

    task automatic set_vld(input logic [3:0] v);
        {mdv_req_vld, agu_req_vld, bjp_req_vld, alu_req_vld} = v;
    endtask

    // Asynchronous reset pulse between edges, with every requester valid
    task automatic async_reset(input string tag);
        set_vld(4'b1111);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        async_reset("reset");

        // Plain round robin over all four
        set_vld(4'b1111);
        for (int i = 0; i < 4; i++) step("rr4");

        // MDV long lock with ALU waiting
        set_vld(4'b1000);
        mdv_req_lock = 1'b1;
        step("mdv_lock_hs");
        set_vld(4'b1001);
        for (int i = 0; i < 33; i++) step("mdv_lock_hold");
        mdv_req_lock = 1'b0;
        step("mdv_release");
        set_vld(4'b0001);
        step("alu_after_release");

        // AGU lock with competing MDV buffer enables
        set_vld(4'b1100);
        agu_req_lock = 1'b1;
        agu_sbf_ena_in = 2'b11;
        mdv_sbf_ena_in = 2'b01;
        for (int i = 0; i < 3; i++) step("agu_lock_sbf");
        set_vld(4'b1000);
        for (int i = 0; i < 2; i++) step("agu_vld_drop");

        // Watchdog: keep the lock past LOCK_TO, then release, flush, idle
        set_vld(4'b0100);
        for (int i = 0; i < 70; i++) step("watchdog");
        agu_req_lock = 1'b0;
        step("wd_release");
        set_vld(4'b0000);
        flush = 1'b1;
        step("wd_flush");
        flush = 1'b0;
        step("wd_sticky");

        // Flush colliding with an MDV lock handshake
        set_vld(4'b1000);
        mdv_req_lock = 1'b1;
        flush = 1'b1;
        step("flush_hs");
        flush = 1'b0;
        set_vld(4'b0000);
        step("flush_after");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_vld(4'($urandom_range(0, 15)));
            agu_req_lock   = 1'($urandom_range(0, 1));
            mdv_req_lock   = 1'($urandom_range(0, 1));
            agu_sbf_ena_in = 2'($urandom_range(0, 3));
            mdv_sbf_ena_in = 2'($urandom_range(0, 3));
            flush          = ($urandom_range(0, 15) == 0);
            step("rand");
        end
        flush = 1'b0;

        // Async reset in the middle of an AGU lock
        set_vld(4'b0100);
        agu_req_lock = 1'b1;
        for (int i = 0; i < 3; i++) step("pre_rst_lock");
        async_reset("mid_lock_rst");
        agu_req_lock = 1'b0;
        mdv_req_lock = 1'b0;
        set_vld(4'b1111);
        step("post_rst_alu");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
